// File: rtl/pio_sm_ctrl_pkg.sv
// pio_ctrl_pkg: address map, CTRL field positions and reset constants
// shared by the PIO SM control block and its clock divider.
package pio_ctrl_pkg;

    localparam logic [3:0] ADDR_CTRL    = 4'h0;
    localparam logic [3:0] ADDR_CLKDIV0 = 4'h1;
    localparam logic [3:0] ADDR_INSTR0  = 4'h5;

    localparam int CTRL_EN_LSB     = 0;
    localparam int CTRL_RST_LSB    = 4;
    localparam int CTRL_DIVRST_LSB = 8;

    localparam logic [31:0] CLKDIV_RESET = 32'h0001_0000;

    // INT==0 encodes the maximum divisor of 65536
    function automatic logic [16:0] div_reload(input logic [15:0] int_div);
        return (int_div == 16'd0) ? 17'h1_0000 : {1'b0, int_div};
    endfunction

endpackage

// File: rtl/pio_sm_ctrl_if.sv
// pio_sm_ctrl_if: register bus between the host and the PIO SM control
// block. master drives address/strobes/data, slave returns read data.
interface pio_sm_ctrl_if;

    logic [3:0]  bus_addr;
    logic        bus_wr;
    logic        bus_rd;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr, bus_wr, bus_rd, bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr, bus_wr, bus_rd, bus_wdata,
        output bus_rdata
    );

endinterface

// File: rtl/pio_sm_ctrl_clkdiv.sv
// pio_clkdiv: per-SM fractional clock divider producing the penable strobe.
// Fractional accumulation is built only when PIO_CLKDIV_FRAC_EN is defined.
module pio_clkdiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        restart,
    input  logic [15:0] int_div,
    input  logic [7:0]  frac_div,
    output logic        penable
);
    import pio_ctrl_pkg::*;

    logic [16:0] r_cnt;

`ifdef PIO_CLKDIV_FRAC_EN
    logic [7:0] r_acc;
    logic [8:0] w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, frac_div};

    // count down; on reload add the fractional carry to the period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 17'd1;
            r_acc <= 8'd0;
        end else if (restart || !en) begin
            r_cnt <= 17'd1;
            r_acc <= 8'd0;
        end else if (r_cnt == 17'd1) begin
            r_acc <= w_sum[7:0];
            r_cnt <= div_reload(int_div) + {16'd0, w_sum[8]};
        end else begin
            r_cnt <= r_cnt - 17'd1;
        end
    end
`else
    logic w_unused_frac;

    assign w_unused_frac = ^frac_div;

    // pure integer countdown, reloaded with the divisor
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 17'd1;
        end else if (restart || !en) begin
            r_cnt <= 17'd1;
        end else if (r_cnt == 17'd1) begin
            r_cnt <= div_reload(int_div);
        end else begin
            r_cnt <= r_cnt - 17'd1;
        end
    end
`endif

    assign penable = en && (r_cnt == 17'd1);

endmodule

// File: rtl/pio_sm_ctrl.sv
// pio_sm_ctrl: CTRL/CLKDIV/INSTR registers and enable/restart/penable/
// forced-instruction generation per SM. Macro: PIO_CLKDIV_FRAC_EN.
module pio_sm_ctrl #(
    parameter int NUM_SM = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    pio_sm_ctrl_if.slave         bus,
    output logic [NUM_SM-1:0]    sm_enable,
    output logic [NUM_SM-1:0]    sm_restart,
    output logic [NUM_SM-1:0]    penable,
    output logic [NUM_SM-1:0]    exec_force,
    output logic [16*NUM_SM-1:0] exec_instr
);
    import pio_ctrl_pkg::*;

    logic [NUM_SM-1:0]    r_sm_enable;
    logic [NUM_SM-1:0]    r_sm_restart;
    logic [NUM_SM-1:0]    r_exec_force;
    logic [16*NUM_SM-1:0] r_exec_instr;
    logic [15:0]          r_clkdiv_int [NUM_SM];
`ifdef PIO_CLKDIV_FRAC_EN
    logic [7:0]           r_clkdiv_frac [NUM_SM];
`endif
    logic [31:0]          r_rdata;
    logic [31:0]          w_rdata;
    logic                 w_ctrl_wr;
    logic [NUM_SM-1:0]    w_div_restart;

    assign w_ctrl_wr = bus.bus_wr && (bus.bus_addr == ADDR_CTRL);

    // counter restart acts on the write edge itself
    assign w_div_restart = w_ctrl_wr ?
        bus.bus_wdata[CTRL_DIVRST_LSB +: NUM_SM] : '0;

    // register writes, one-cycle pulses and registered read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sm_enable  <= '0;
            r_sm_restart <= '0;
            r_exec_force <= '0;
            r_exec_instr <= '0;
            r_rdata      <= '0;
            for (int i = 0; i < NUM_SM; i++) begin
                r_clkdiv_int[i]  <= CLKDIV_RESET[31:16];
`ifdef PIO_CLKDIV_FRAC_EN
                r_clkdiv_frac[i] <= CLKDIV_RESET[15:8];
`endif
            end
        end else begin
            r_sm_restart <= '0;
            r_exec_force <= '0;
            if (w_ctrl_wr) begin
                r_sm_enable  <= bus.bus_wdata[CTRL_EN_LSB +: NUM_SM];
                r_sm_restart <= bus.bus_wdata[CTRL_RST_LSB +: NUM_SM];
            end
            if (bus.bus_wr) begin
                for (int i = 0; i < NUM_SM; i++) begin
                    if (bus.bus_addr == ADDR_CLKDIV0 + 4'(i)) begin
                        r_clkdiv_int[i]  <= bus.bus_wdata[31:16];
`ifdef PIO_CLKDIV_FRAC_EN
                        r_clkdiv_frac[i] <= bus.bus_wdata[15:8];
`endif
                    end
                    if (bus.bus_addr == ADDR_INSTR0 + 4'(i)) begin
                        r_exec_instr[16*i +: 16] <= bus.bus_wdata[15:0];
                        r_exec_force[i]          <= 1'b1;
                    end
                end
            end
            if (bus.bus_rd) begin
                r_rdata <= w_rdata;
            end
        end
    end

    // read mux over current register values (old value on same-cycle write)
    always_comb begin
        w_rdata = '0;
        if (bus.bus_addr == ADDR_CTRL) begin
            w_rdata[CTRL_EN_LSB +: NUM_SM] = r_sm_enable;
        end
        for (int i = 0; i < NUM_SM; i++) begin
            if (bus.bus_addr == ADDR_CLKDIV0 + 4'(i)) begin
`ifdef PIO_CLKDIV_FRAC_EN
                w_rdata = {r_clkdiv_int[i], r_clkdiv_frac[i], 8'h00};
`else
                w_rdata = {r_clkdiv_int[i], 16'h0000};
`endif
            end
            if (bus.bus_addr == ADDR_INSTR0 + 4'(i)) begin
                w_rdata = {16'h0000, r_exec_instr[16*i +: 16]};
            end
        end
    end

    for (genvar g = 0; g < NUM_SM; g++) begin : g_div
        logic [7:0] w_frac;
`ifdef PIO_CLKDIV_FRAC_EN
        assign w_frac = r_clkdiv_frac[g];
`else
        assign w_frac = 8'h00;
`endif
        pio_clkdiv u_div (
            .clk      (clk),
            .reset    (reset),
            .en       (r_sm_enable[g]),
            .restart  (w_div_restart[g]),
            .int_div  (r_clkdiv_int[g]),
            .frac_div (w_frac),
            .penable  (penable[g])
        );
    end

    assign bus.bus_rdata = r_rdata;
    assign sm_enable     = r_sm_enable;
    assign sm_restart    = r_sm_restart;
    assign exec_force    = r_exec_force;
    assign exec_instr    = r_exec_instr;

endmodule

// File: tb/tb_pio_sm_ctrl.sv
// tb_pio_sm_ctrl: table-driven register/strobe vectors plus divider,
// max-divisor, forced-instruction and async-reset sequences.
module tb_pio_sm_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  sm_enable;
    logic [3:0]  sm_restart;
    logic [3:0]  penable;
    logic [3:0]  exec_force;
    logic [63:0] exec_instr;

    int total = 0;
    int bad   = 0;

    pio_sm_ctrl_if bus ();

    pio_sm_ctrl #(.NUM_SM(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .sm_enable  (sm_enable),
        .sm_restart (sm_restart),
        .penable    (penable),
        .exec_force (exec_force),
        .exec_instr (exec_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  en;
        logic [3:0]  rst;
        logic [3:0]  frc;
        logic [3:0]  pen;
        logic        chk_rd;
        logic [31:0] rdata;
        logic [63:0] instr;
    } vec_t;

`ifdef PIO_CLKDIV_FRAC_EN
    localparam logic [31:0] CD1_RD  = 32'h1234_AB00;
    localparam logic [12:0] FR_PAT  = 13'b1_0100_1010_0101;
`else
    localparam logic [31:0] CD1_RD  = 32'h1234_0000;
    localparam logic [12:0] FR_PAT  = 13'b1_0101_0101_0101;
`endif
    localparam logic [63:0] I5 = 64'h0000_0005_0000_0000;

    vec_t tv [18];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one bus cycle: drive after negedge, sample 1ns after the edge
    task automatic step(input logic wr, input logic rd,
                        input logic [3:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.bus_wr    = wr;
        bus.bus_rd    = rd;
        bus.bus_addr  = addr;
        bus.bus_wdata = wdata;
        @(posedge clk);
        #1;
        bus.bus_wr = 1'b0;
        bus.bus_rd = 1'b0;
    endtask

    initial begin
        logic [8:0]  pat3;
        logic [12:0] patf;
        int          gap;
        logic        stray;

        tv[0]  = '{0,1,4'h0,32'h0,        4'h0,4'h0,4'h0,4'h0,1,32'h0,        64'h0};
        tv[1]  = '{0,1,4'h1,32'h0,        4'h0,4'h0,4'h0,4'h0,1,32'h0001_0000,64'h0};
        tv[2]  = '{0,1,4'h4,32'h0,        4'h0,4'h0,4'h0,4'h0,1,32'h0001_0000,64'h0};
        tv[3]  = '{1,0,4'h0,32'h1,        4'h1,4'h0,4'h0,4'h1,0,32'h0,        64'h0};
        tv[4]  = '{0,0,4'h0,32'h0,        4'h1,4'h0,4'h0,4'h1,0,32'h0,        64'h0};
        tv[5]  = '{1,0,4'h0,32'h21,       4'h1,4'h2,4'h0,4'h1,0,32'h0,        64'h0};
        tv[6]  = '{0,0,4'h0,32'h0,        4'h1,4'h0,4'h0,4'h1,0,32'h0,        64'h0};
        tv[7]  = '{1,0,4'h7,32'h5,        4'h1,4'h0,4'h4,4'h1,0,32'h0,        I5};
        tv[8]  = '{0,0,4'h0,32'h0,        4'h1,4'h0,4'h0,4'h1,0,32'h0,        I5};
        tv[9]  = '{0,1,4'h7,32'h0,        4'h1,4'h0,4'h0,4'h1,1,32'h5,        I5};
        tv[10] = '{1,0,4'h2,32'h1234_ABCD,4'h1,4'h0,4'h0,4'h1,0,32'h0,        I5};
        tv[11] = '{0,1,4'h2,32'h0,        4'h1,4'h0,4'h0,4'h1,1,CD1_RD,       I5};
        tv[12] = '{1,0,4'hF,32'hFFFF_FFFF,4'h1,4'h0,4'h0,4'h1,0,32'h0,        I5};
        tv[13] = '{0,1,4'hF,32'h0,        4'h1,4'h0,4'h0,4'h1,1,32'h0,        I5};
        tv[14] = '{0,1,4'h9,32'h0,        4'h1,4'h0,4'h0,4'h1,1,32'h0,        I5};
        tv[15] = '{1,1,4'h0,32'h3,        4'h3,4'h0,4'h0,4'h3,1,32'h1,        I5};
        tv[16] = '{0,1,4'h0,32'h0,        4'h3,4'h0,4'h0,4'h1,1,32'h3,        I5};
        tv[17] = '{1,0,4'h0,32'h0,        4'h0,4'h0,4'h0,4'h0,0,32'h0,        I5};

        bus.bus_wr    = 1'b0;
        bus.bus_rd    = 1'b0;
        bus.bus_addr  = 4'h0;
        bus.bus_wdata = 32'h0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_en",    64'(sm_enable),  64'h0);
        chk("reset_pen",   64'(penable),    64'h0);
        chk("reset_rdata", 64'(bus.bus_rdata), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step(tv[i].wr, tv[i].rd, tv[i].addr, tv[i].wdata);
            chk($sformatf("v%0d_en", i),    64'(sm_enable),  64'(tv[i].en));
            chk($sformatf("v%0d_rst", i),   64'(sm_restart), 64'(tv[i].rst));
            chk($sformatf("v%0d_frc", i),   64'(exec_force), 64'(tv[i].frc));
            chk($sformatf("v%0d_pen", i),   64'(penable),    64'(tv[i].pen));
            chk($sformatf("v%0d_instr", i), exec_instr,      tv[i].instr);
            if (tv[i].chk_rd)
                chk($sformatf("v%0d_rdata", i), 64'(bus.bus_rdata),
                    64'(tv[i].rdata));
        end

        // INT=3: pulses at N+1, N+4, N+7
        step(1, 0, 4'h1, 32'h0003_0000);
        step(1, 0, 4'h0, 32'h1);
        pat3 = '0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) step(0, 0, 4'h0, 32'h0);
            pat3[k] = penable[0];
        end
        chk("div3_pattern", 64'(pat3), 64'h049);
        step(1, 0, 4'h0, 32'h0);

        // INT=2 FRAC=0x80
        step(1, 0, 4'h1, 32'h0002_8000);
        step(1, 0, 4'h0, 32'h1);
        patf = '0;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) step(0, 0, 4'h0, 32'h0);
            patf[k] = penable[0];
        end
        chk("frac_pattern", 64'(patf), 64'(FR_PAT));
        step(1, 0, 4'h0, 32'h0);

        // maximum divisor, SM0/SM1 enabled and restarted together
        step(1, 0, 4'h1, 32'h0);
        step(1, 0, 4'h2, 32'h0);
        step(1, 0, 4'h0, 32'h303);
        chk("max_first_pen", 64'(penable), 64'h3);
        gap = 0;
        stray = 1'b0;
        for (int c = 1; c <= 70000; c++) begin
            step(0, 0, 4'h0, 32'h0);
            if (penable[0]) begin
                gap = c;
                break;
            end
            if (penable != 4'h0) stray = 1'b1;
        end
        chk("max_gap", 64'(gap), 64'd65536);
        chk("max_pen_pair", 64'(penable), 64'h3);
        chk("max_no_stray", 64'(stray), 64'h0);
        step(1, 0, 4'h0, 32'h0);

        // asynchronous reset mid-period with live pulses
        step(1, 0, 4'h1, 32'h0005_0000);
        step(1, 0, 4'h5, 32'h00AB);
        step(0, 1, 4'h1, 32'h0);
        chk("pre_rst_rdata", 64'(bus.bus_rdata), 64'h0005_0000);
        step(1, 0, 4'h0, 32'h11);
        chk("pre_rst_pulse", 64'({sm_restart, sm_enable, penable}),
            64'h111);
        step(0, 0, 4'h0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_outs",
            64'({sm_enable, sm_restart, exec_force, penable}), 64'h0);
        chk("async_rst_instr", exec_instr, 64'h0);
        chk("async_rst_rdata", 64'(bus.bus_rdata), 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step(0, 1, 4'h1, 32'h0);
        chk("post_rst_clkdiv", 64'(bus.bus_rdata), 64'h0001_0000);
        chk("post_rst_en_pen", 64'({sm_enable, penable}), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pio_sm_ctrl.md
# pio_sm_ctrl

Per-PIO control and scheduling block for the state machines. It holds the CTRL, CLKDIV and INSTR registers for each SM and generates `sm_enable`, `sm_restart` and the fractional-clock-divided `penable` strobe that paces each SM's decode. It also generates the forced-instruction pulse (`flag_abnormal`/`jmp_data`). It sits between the register bus and the `NUM_SM` state-machine instances.

## Interface
- `NUM_SM`, default 4: number of state machines served (1..4).
- `clk`  in  1: clock.
- `reset`  in  1: reset, asynchronous, active-high.
- `bus_addr`  in  4: register word address.
- `bus_wr`  in  1: write strobe, one cycle per write.
- `bus_rd`  in  1: read strobe.
- `bus_wdata`  in  32: write data.
- `bus_rdata`  out  32: read data, registered.
- `sm_enable`  out  NUM_SM: per-SM enable, level.
- `sm_restart`  out  NUM_SM: one-cycle restart pulse.
- `penable`  out  NUM_SM: divided clock-enable strobe.
- `exec_force`  out  NUM_SM: one-cycle forced-execute pulse. Drives the SM's `flag_abnormal`.
- `exec_instr`  out  16*NUM_SM: forced instruction word, slice i for SM i. Drives the SM's `jmp_data`.

## Operation
- Address map:
  - 0x0: CTRL. Bits [3:0] SM_ENABLE (read/write). Bits [7:4] SM_RESTART (write-1 pulse, reads 0). Bits [11:8] CLKDIV_RESTART (write-1 pulse, reads 0).
  - 0x1+i: CLKDIV for SM i. Bits [31:16] INT, bits [15:8] FRAC, bits [7:0] read 0.
  - 0x5+i: INSTR for SM i. Bits [15:0]; reads return the last written value.
  - Unmapped addresses and SM indices >= NUM_SM: writes are ignored, reads return 0.
- Divider state per SM:
  - `cnt` (17 bits) and `acc` (8 bits).
  - Reload divisor = INT, where INT==0 means 65536.
- Each cycle, for each SM:
  - If `sm_enable[i]`=0: hold `cnt`=1 and `acc`=0.
  - If enabled and `cnt`==1: set {carry,`acc`} <= `acc`+FRAC, then `cnt` <= divisor+carry.
  - If enabled and `cnt`!=1: `cnt` <= `cnt`-1.
- `penable[i]` = `sm_enable[i]` && `cnt[i]`==1. This is combinational from registers.
- CLKDIV_RESTART bit i: forces `cnt`=1 and `acc`=0 on the write edge. Bits set in the same write leave those SMs phase-aligned.
- A CLKDIV write takes effect at the next reload. It never truncates the current period.
- SM_RESTART bit i pulses `sm_restart[i]` for one cycle. It does not change `sm_enable`.
- An INSTR write to SM i:
  - latches `exec_instr[i]`;
  - pulses `exec_force[i]` regardless of `sm_enable`. The SM gates it itself.
- A CTRL write that sets SM_ENABLE and CLKDIV_RESTART together is applied in one edge: the SM is enabled and its counter restarts.

## Timing
- Reset values:
  - `sm_enable`, `sm_restart`, `exec_force`, `exec_instr` and `bus_rdata` = 0.
  - CLKDIV = 0x00010000 (INT=1, FRAC=0).
  - `cnt`=1, `acc`=0.
  - Therefore `penable`=0.
- Reset mid-operation clears all of the above immediately, with no partial pulses.
- Register write on edge N:
  - `sm_enable`, `sm_restart` and `exec_force` change after edge N and are valid in cycle N+1.
  - Pulses deassert after edge N+1.
- First `penable` after enabling appears in cycle N+1. It then repeats every divisor(+carry) cycles.
- INT=1, FRAC=0: `penable` is high on every enabled cycle.
- INT=2, FRAC=0x80: periods alternate 2 and 3 cycles, starting with 2.
- Read: `bus_rdata` is valid one cycle after `bus_rd` and holds until the next read.
- Read and write to the same address in the same cycle: the read returns the old value.

## Configuration
- `PIO_CLKDIV_FRAC_EN` defined: fractional accumulation operates as described.
- `PIO_CLKDIV_FRAC_EN` undefined:
  - FRAC bits are not stored and read 0;
  - `acc` is removed;
  - carry is always 0, giving pure integer division.

## Structure
- Package `pio_ctrl_pkg` holds:
  - address constants (`ADDR_CTRL`, `ADDR_CLKDIV0`, `ADDR_INSTR0`);
  - CTRL bit-field positions;
  - `CLKDIV_RESET` = 32'h00010000.
- Sub-module `pio_clkdiv`: one instance per SM via generate.
  - Inputs: `clk`, `reset`, `en`, `restart`, `int_div[15:0]`, `frac_div[7:0]`.
  - Output: `penable`.

## Test plan
- Reset, then write CTRL=0x1 -> `sm_enable`=4'b0001 and `penable[0]` high on every cycle from N+1; `penable[3:1]`=0.
- Write CLKDIV0=0x00030000, enable SM0 -> `penable[0]` high in cycles N+1, N+4, N+7.
- Write CLKDIV0=0x00028000 -> `penable[0]` gaps 2,3,2,3 with the macro defined; constant 2 with the macro undefined.
- Write CLKDIV0=0 and CLKDIV1=0, then CTRL=0x303 -> `penable[0]` and `penable[1]` fire in the same cycle, 65536 cycles apart.
- Write INSTR2=0x0005 -> `exec_force`=4'b0100 for exactly one cycle; `exec_instr[47:32]`=0x0005 and holds.
- Assert `reset` mid-period with CLKDIV0=0x00050000 -> all outputs 0 immediately; after release, read CLKDIV0 returns 0x00010000.
